dual_issue_scoreboard: RTL

Register scoreboard and decode-stall generator for the dual-issue pipeline. It tracks destination registers whose values cannot yet be forwarded: loads between issue and writeback, and the fixed-latency iterative divider. It produces the decode stall and bundle-split controls that the forwarding network depends on. It sits beside the decode stage, takes issue information from both decode slots and writeback information from both writeback slots, and owns the divider-busy countdown.

---
 rtl/dual_issue_scoreboard.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dual_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scoreboard
// Description : Register scoreboard, divider countdown and decode stall/split
//               generation for the dual-issue pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scoreboard #(
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_D1,
    input  logic        valid_D2,
    input  logic [4:0]  rs_D1,
    input  logic [4:0]  rt_D1,
    input  logic [4:0]  rs_D2,
    input  logic [4:0]  rt_D2,
    input  logic        useRs_D1,
    input  logic        useRt_D1,
    input  logic        useRs_D2,
    input  logic        useRt_D2,
    input  logic        regWrite_D1,
    input  logic        regWrite_D2,
    input  logic [4:0]  writeReg_D1,
    input  logic [4:0]  writeReg_D2,
    input  logic        isLoad_D1,
    input  logic        isLoad_D2,
    input  logic        isDiv_D1,
    input  logic        loadDone_W1,
    input  logic        loadDone_W2,
    input  logic [4:0]  writeReg_W1,
    input  logic [4:0]  writeReg_W2,
    output logic        stall_D,
    output logic        split_D,
    output logic        div_busy,
    output logic        div_done,
    output logic [4:0]  div_dest,
    output logic [31:0] pending
);

    localparam int             CW       = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0]  C_LAT    = CW'(DIV_LAT);
    localparam logic [CW-1:0]  C_ONE    = CW'(1);

    logic [31:0]   pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic          div_done_q, div_done_d;
    logic [4:0]    div_dest_q, div_dest_d;

    logic          w_haz1, w_haz2, w_raw, w_stall, w_split;
    logic          w_issue1, w_issue2, w_div_go;
    logic [31:0]   w_set, w_clr;

    function automatic logic haz(input logic use_i, input logic [4:0] reg_i,
                                 input logic [31:0] pend_i);
        return use_i & (reg_i != 5'd0) & pend_i[reg_i];
    endfunction

    always_comb begin
        w_haz1 = haz(useRs_D1, rs_D1, pending_q) | haz(useRt_D1, rt_D1, pending_q);
        w_haz2 = haz(useRs_D2, rs_D2, pending_q) | haz(useRt_D2, rt_D2, pending_q);
        w_raw  = regWrite_D1 & (writeReg_D1 != 5'd0) &
                 ((useRs_D2 & (rs_D2 == writeReg_D1)) |
                  (useRt_D2 & (rt_D2 == writeReg_D1)));

        // A divide may enter in the completion cycle of the previous one.
        w_stall = w_haz1 |
                  (isDiv_D1 & valid_D1 & (count_q != '0) & ~div_done_q) |
                  (~valid_D1 & w_haz2);
        w_split = ~w_stall & valid_D2 & (w_haz2 | w_raw | (isLoad_D2 & isLoad_D1));

        w_issue1 = valid_D1 & ~w_stall;
        w_issue2 = valid_D2 & ~w_stall & ~w_split;
        w_div_go = w_issue1 & isDiv_D1;

        w_clr = '0;
        if (loadDone_W1) w_clr[writeReg_W1] = 1'b1;
        if (loadDone_W2) w_clr[writeReg_W2] = 1'b1;
        if (div_done_q)  w_clr[div_dest_q]  = 1'b1;

        w_set = '0;
        if (w_issue1 & isLoad_D1 & regWrite_D1) w_set[writeReg_D1] = 1'b1;
        if (w_div_go)                           w_set[writeReg_D1] = 1'b1;
        if (w_issue2 & isLoad_D2 & regWrite_D2) w_set[writeReg_D2] = 1'b1;

        // Set is applied after clear so a new producer keeps ownership.
        pending_d    = (pending_q & ~w_clr) | w_set;
        pending_d[0] = 1'b0;

        if (w_div_go) begin
            count_d    = C_LAT;
            div_dest_d = writeReg_D1;
        end else begin
            count_d    = (count_q != '0) ? (count_q - C_ONE) : count_q;
            div_dest_d = div_dest_q;
        end
        div_done_d = (count_d == C_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            count_q    <= '0;
            div_done_q <= 1'b0;
            div_dest_q <= '0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            div_done_q <= div_done_d;
            div_dest_q <= div_dest_d;
        end
    end

    assign stall_D  = w_stall;
    assign split_D  = w_split;
    assign div_busy = (count_q != '0);
    assign div_done = div_done_q;
    assign div_dest = div_dest_q;
    assign pending  = pending_q;

endmodule
`default_nettype wire
